// File: rtl/exe_pkg.sv
// exe_pkg: shared ALU encodings, shifter types, FSM states and control bundle for the execute stage.
package exe_pkg;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} exe_state_e;

    typedef struct packed {
        logic mem_r;
        logic mem_w;
        logic wb;
        logic br;
    } ctrl_t;
endpackage

// File: rtl/exe_val2_gen.sv
// exe_val2_gen: second-operand generator (rotated immediate, memory offset or shifted register).
module exe_val2_gen
    import exe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              imm_i,
    input  logic              mem_en_i,
    input  logic [11:0]       shift_operand_i,
    input  logic [DATA_W-1:0] val_rm_i,
    output logic [DATA_W-1:0] val2_o
);
    logic [4:0]        rot;
    logic [4:0]        amt;
    logic [1:0]        typ;
    logic [6:0]        ror_back;
    logic [63:0]       imm_dbl;
    logic [DATA_W-1:0] imm_val;
    logic [DATA_W-1:0] mem_val;
    logic [DATA_W-1:0] asr_val;
    logic [DATA_W-1:0] ror_val;
    logic [DATA_W-1:0] sh_val;

    assign rot      = {shift_operand_i[11:8], 1'b0};
    assign amt      = shift_operand_i[11:7];
    assign typ      = shift_operand_i[6:5];
    // Immediate rotation is always 32-bit wide, even on a 64-bit datapath.
    assign imm_dbl  = {2{24'b0, shift_operand_i[7:0]}} >> rot;
    assign imm_val  = DATA_W'(imm_dbl[31:0]);
    assign mem_val  = DATA_W'(shift_operand_i);
    assign asr_val  = DATA_W'($signed(val_rm_i) >>> amt);
    assign ror_back = 7'(DATA_W) - {2'b00, amt};
    assign ror_val  = (val_rm_i >> amt) | (val_rm_i << ror_back);
    assign sh_val   = typ == SH_LSL ? val_rm_i << amt :
                      typ == SH_LSR ? val_rm_i >> amt :
                      typ == SH_ASR ? asr_val : ror_val;
    assign val2_o   = imm_i ? imm_val : mem_en_i ? mem_val : sh_val;
endmodule

// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: execute stage with EX/MEM register, NZCV register and iterative shift-add multiplier.
module exe_stage_pipe
    import exe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IMM_W    = 24,
    parameter int MUL_LAT  = 4,
    parameter int BR_SHIFT = 2
) (
    input  logic              clk_i,
    input  logic              rest_ni,
    input  logic              flush_i,
    input  logic              freeze_i,
    input  logic              in_valid_i,
    input  logic              mem_r_en_i,
    input  logic              mem_w_en_i,
    input  logic              wb_en_i,
    input  logic              s_bit_i,
    input  logic              branch_i,
    input  logic [3:0]        exe_cmd_i,
    input  logic [3:0]        dest_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] val1_i,
    input  logic [DATA_W-1:0] val_rm_i,
    input  logic              imm_i,
    input  logic [11:0]       shift_operand_i,
    input  logic [IMM_W-1:0]  signed_imm_i,
    output logic              exe_busy_o,
    output logic              out_valid_o,
    output logic              out_mem_r_en_o,
    output logic              out_mem_w_en_o,
    output logic              out_wb_en_o,
    output logic              out_branch_o,
    output logic [3:0]        out_dest_o,
    output logic [DATA_W-1:0] alu_res_o,
    output logic [DATA_W-1:0] val_rm_out_o,
    output logic [DATA_W-1:0] branch_address_o,
    output logic [3:0]        status_bits_o
);
    localparam int CH = DATA_W / MUL_LAT;
    localparam int CW = $clog2(MUL_LAT + 1);

    exe_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [3:0]        dest_q, dest_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] rm_q, rm_d;
    logic [DATA_W-1:0] ba_q, ba_d;
    logic [3:0]        nzcv_q, nzcv_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    ctrl_t             p_ctrl_q, p_ctrl_d;
    logic              p_s_q, p_s_d;
    logic [3:0]        p_dest_q, p_dest_d;
    logic [DATA_W-1:0] p_rm_q, p_rm_d;
    logic [DATA_W-1:0] p_ba_q, p_ba_d;

    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] simm_ext;
    logic [DATA_W-1:0] br_addr;
    logic              is_add;
    logic              is_sub;
    logic              arith;
    logic              cin;
    logic [DATA_W-1:0] bb;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] logic_res;
    logic [DATA_W-1:0] alu_res;
    logic              alu_v;
    logic [DATA_W-1:0] part;
    logic [DATA_W-1:0] acc_nx;
    ctrl_t             in_ctrl;

    exe_val2_gen #(.DATA_W(DATA_W)) u_val2 (
        .imm_i           (imm_i),
        .mem_en_i        (mem_r_en_i | mem_w_en_i),
        .shift_operand_i (shift_operand_i),
        .val_rm_i        (val_rm_i),
        .val2_o          (val2)
    );

    assign simm_ext = {{(DATA_W-IMM_W){signed_imm_i[IMM_W-1]}}, signed_imm_i};
    assign br_addr  = pc_i + (simm_ext << BR_SHIFT);
    assign in_ctrl  = '{mem_r: mem_r_en_i, mem_w: mem_w_en_i, wb: wb_en_i, br: branch_i};

    // Subtraction is a + ~b + carry-in, so C comes out directly as NOT borrow.
    assign is_add    = exe_cmd_i == CMD_ADD || exe_cmd_i == CMD_ADC;
    assign is_sub    = exe_cmd_i == CMD_SUB || exe_cmd_i == CMD_SBC;
    assign arith     = is_add | is_sub;
    assign cin       = exe_cmd_i == CMD_ADD ? 1'b0 : exe_cmd_i == CMD_SUB ? 1'b1 : nzcv_q[1];
    assign bb        = is_sub ? ~val2 : val2;
    assign sum       = {1'b0, val1_i} + {1'b0, bb} + (DATA_W+1)'(cin);
    assign alu_v     = (val1_i[DATA_W-1] == bb[DATA_W-1]) && (sum[DATA_W-1] != val1_i[DATA_W-1]);
    assign logic_res = exe_cmd_i == CMD_MVN ? ~val2 :
                       exe_cmd_i == CMD_AND ? val1_i & val2 :
                       exe_cmd_i == CMD_ORR ? val1_i | val2 :
                       exe_cmd_i == CMD_EOR ? val1_i ^ val2 : val2;
    assign alu_res   = arith ? sum[DATA_W-1:0] : logic_res;

    always_comb begin
        part = '0;
        for (int j = 0; j < CH; j++)
            part = mplier_q[j] ? part + (mcand_q << j) : part;
    end

    assign acc_nx = acc_q + part;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        dest_d   = dest_q;
        res_d    = res_q;
        rm_d     = rm_q;
        ba_d     = ba_q;
        nzcv_d   = nzcv_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        p_ctrl_d = p_ctrl_q;
        p_s_d    = p_s_q;
        p_dest_d = p_dest_q;
        p_rm_d   = p_rm_q;
        p_ba_d   = p_ba_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (!freeze_i) begin
            if (state_q == ST_IDLE) begin
                valid_d = in_valid_i && exe_cmd_i != CMD_MUL;
                ctrl_d  = valid_d ? in_ctrl : '0;
                if (in_valid_i && exe_cmd_i == CMD_MUL) begin
                    state_d  = ST_MUL;
                    cnt_d    = '0;
                    mcand_d  = val1_i;
                    mplier_d = val_rm_i;
                    acc_d    = '0;
                    p_ctrl_d = in_ctrl;
                    p_s_d    = s_bit_i;
                    p_dest_d = dest_i;
                    p_rm_d   = val_rm_i;
                    p_ba_d   = br_addr;
                end else if (in_valid_i) begin
                    dest_d = dest_i;
                    res_d  = alu_res;
                    rm_d   = val_rm_i;
                    ba_d   = br_addr;
                    nzcv_d = s_bit_i ? {alu_res[DATA_W-1], alu_res == '0,
                                        arith ? sum[DATA_W] : nzcv_q[1],
                                        arith ? alu_v : nzcv_q[0]} : nzcv_q;
                end
            end else begin
                mcand_d  = mcand_q << CH;
                mplier_d = mplier_q >> CH;
                acc_d    = acc_nx;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(MUL_LAT - 1)) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b1;
                    ctrl_d  = p_ctrl_q;
                    dest_d  = p_dest_q;
                    res_d   = acc_nx;
                    rm_d    = p_rm_q;
                    ba_d    = p_ba_q;
                    nzcv_d  = p_s_q ? {acc_nx[DATA_W-1], acc_nx == '0, nzcv_q[1:0]} : nzcv_q;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rest_ni) begin
        if (!rest_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            dest_q   <= '0;
            res_q    <= '0;
            rm_q     <= '0;
            ba_q     <= '0;
            nzcv_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            p_ctrl_q <= '0;
            p_s_q    <= 1'b0;
            p_dest_q <= '0;
            p_rm_q   <= '0;
            p_ba_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            dest_q   <= dest_d;
            res_q    <= res_d;
            rm_q     <= rm_d;
            ba_q     <= ba_d;
            nzcv_q   <= nzcv_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            p_ctrl_q <= p_ctrl_d;
            p_s_q    <= p_s_d;
            p_dest_q <= p_dest_d;
            p_rm_q   <= p_rm_d;
            p_ba_q   <= p_ba_d;
        end
    end

    assign exe_busy_o       = state_q == ST_MUL || freeze_i;
    assign out_valid_o      = valid_q;
    assign out_mem_r_en_o   = ctrl_q.mem_r;
    assign out_mem_w_en_o   = ctrl_q.mem_w;
    assign out_wb_en_o      = ctrl_q.wb;
    assign out_branch_o     = ctrl_q.br;
    assign out_dest_o       = dest_q;
    assign alu_res_o        = res_q;
    assign val_rm_out_o     = rm_q;
    assign branch_address_o = ba_q;
    assign status_bits_o    = nzcv_q;
endmodule
